// File: rtl/mem_router_pkg.sv
// Shared types for the memory request router: target ids (including the
// decode-error marker) and helpers used by the router and its FIFOs.
package mem_router_pkg;

  // Largest supported target count; ids are sized so that every target
  // index plus the decode-error marker (id == NUM_TGT) always fits.
  localparam int MAX_TGT  = 4;
  localparam int TGT_ID_W = $clog2(MAX_TGT + 1);

  typedef logic [TGT_ID_W-1:0] tgt_id_t;

  // Error marker for the default two-target build. Instances with a
  // different target count derive their own marker via tgt_err_id().
  localparam tgt_id_t TGT_ERR_ID = tgt_id_t'(2);

  // Decode-error marker for a router with num_tgt targets: one past the
  // last real target index.
  function automatic tgt_id_t tgt_err_id(input int num_tgt);
    return tgt_id_t'(num_tgt);
  endfunction

endpackage

// File: rtl/mem_router_fifo.sv
// Small synchronous FIFO with asynchronous active-high reset. Head data is
// read combinationally so a freshly pushed entry is visible the next cycle.
module mem_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_reg[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vproc_mem_router.sv
// Address-window router between the core memory port and NUM_TGT targets.
// Requests are forwarded with zero latency; responses are returned upstream
// strictly in request order using an order FIFO of target ids plus one
// response FIFO per target.
module vproc_mem_router
  import mem_router_pkg::*;
#(
  parameter int                    MEM_W           = 32,
  parameter int                    NUM_TGT         = 2,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE        = {32'h0004_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*32-1:0] TGT_MASK        = {32'hFFFC_0000, 32'hFFFC_0000},
  parameter logic [NUM_TGT*32-1:0] TGT_OFFSET      = {32'h0000_0000, 32'h0000_2000}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_req_i,
  output logic                     mem_gnt_o,
  input  logic [31:0]              mem_addr_i,
  input  logic                     mem_we_i,
  input  logic [MEM_W/8-1:0]       mem_be_i,
  input  logic [MEM_W-1:0]         mem_wdata_i,
  output logic                     mem_rvalid_o,
  output logic                     mem_err_o,
  output logic [MEM_W-1:0]         mem_rdata_o,
  output logic [NUM_TGT-1:0]       tgt_req_o,
  output logic [31:0]              tgt_addr_o,
  output logic                     tgt_we_o,
  output logic [MEM_W/8-1:0]       tgt_be_o,
  output logic [MEM_W-1:0]         tgt_wdata_o,
  input  logic [NUM_TGT-1:0]       tgt_rvalid_i,
  input  logic [NUM_TGT-1:0]       tgt_err_i,
  input  logic [NUM_TGT*MEM_W-1:0] tgt_rdata_i,
  output logic                     proto_err_o
);

  localparam int      CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam tgt_id_t ERR_ID = tgt_err_id(NUM_TGT);

  typedef struct packed {
    logic             err;
    logic [MEM_W-1:0] rdata;
  } resp_t;

  // Request side
  logic             accept;
  logic             fwd;
  logic             dec_hit;
  tgt_id_t          dec_id;
  logic [31:0]      dec_off;

  // Order FIFO
  tgt_id_t          ord_head;
  logic             ord_empty;
  logic             ord_full;

  // Per-target response path
  resp_t            rsp_head [NUM_TGT];
  logic [NUM_TGT-1:0] rsp_empty;
  logic [NUM_TGT-1:0] rsp_full;
  logic [NUM_TGT-1:0] rsp_pop;
  logic [NUM_TGT-1:0] rsp_take;
  logic [NUM_TGT-1:0] stray;
  logic [CNT_W-1:0] pend_cnt_reg [NUM_TGT];

  logic [CNT_W-1:0] out_cnt_reg;
  logic             proto_err_reg;

  // Grant depends only on the registered count, so a pop never opens the
  // gate in the same cycle it happens.
  assign mem_gnt_o = (out_cnt_reg < CNT_W'(MAX_OUTSTANDING)) & ~rst;
  assign accept    = mem_req_i & mem_gnt_o;
  assign fwd       = accept & dec_hit;

  // Address decode; iterating downwards lets the lowest matching window win.
  always_comb begin
    dec_hit = 1'b0;
    dec_id  = ERR_ID;
    dec_off = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((mem_addr_i & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
        dec_hit = 1'b1;
        dec_id  = tgt_id_t'(i);
        dec_off = TGT_OFFSET[i*32 +: 32];
      end
    end
  end

  // Shared target bus is only driven while a request is actually forwarded.
  assign tgt_addr_o  = fwd ? (mem_addr_i + dec_off) : '0;
  assign tgt_we_o    = fwd & mem_we_i;
  assign tgt_be_o    = fwd ? mem_be_i : '0;
  assign tgt_wdata_o = fwd ? mem_wdata_i : '0;

  // Order FIFO: one entry per accepted request, holding the target id or the
  // decode-error marker. It can never be full on accept because its depth
  // equals the outstanding limit.
  mem_router_fifo #(
    .WIDTH (TGT_ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept & ~ord_full),
    .wdata (dec_id),
    .pop   (mem_rvalid_o),
    .rdata (ord_head),
    .full  (ord_full),
    .empty (ord_empty)
  );

  generate
    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
      logic [MEM_W:0] rsp_bits;

      assign tgt_req_o[gi] = fwd & (dec_id == tgt_id_t'(gi));
      // A response is only legal while this target owes us one.
      assign rsp_take[gi]  = tgt_rvalid_i[gi] & (pend_cnt_reg[gi] != '0);
      assign stray[gi]     = tgt_rvalid_i[gi] & (pend_cnt_reg[gi] == '0);
      assign rsp_head[gi]  = resp_t'(rsp_bits);

      // Requests issued to this target that have not yet been answered.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_cnt_reg[gi] <= '0;
        end else if (tgt_req_o[gi] & ~rsp_take[gi]) begin
          pend_cnt_reg[gi] <= pend_cnt_reg[gi] + 1'b1;
        end else if (~tgt_req_o[gi] & rsp_take[gi]) begin
          pend_cnt_reg[gi] <= pend_cnt_reg[gi] - 1'b1;
        end
      end

      // Response FIFO; pending + buffered never exceeds the outstanding
      // limit, so a taken response always finds room.
      mem_router_fifo #(
        .WIDTH (MEM_W + 1),
        .DEPTH (MAX_OUTSTANDING)
      ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_take[gi] & (~rsp_full[gi] | rsp_pop[gi])),
        .wdata ({tgt_err_i[gi], tgt_rdata_i[gi*MEM_W +: MEM_W]}),
        .pop   (rsp_pop[gi]),
        .rdata (rsp_bits),
        .full  (rsp_full[gi]),
        .empty (rsp_empty[gi])
      );
    end
  endgenerate

  // Upstream response: release the order-FIFO head once its data is present.
  always_comb begin
    mem_rvalid_o = 1'b0;
    mem_err_o    = 1'b0;
    mem_rdata_o  = '0;
    rsp_pop      = '0;
    if (!ord_empty) begin
      if (ord_head == ERR_ID) begin
        mem_rvalid_o = 1'b1;
        mem_err_o    = 1'b1;
      end else begin
        for (int i = 0; i < NUM_TGT; i++) begin
          if ((ord_head == tgt_id_t'(i)) && !rsp_empty[i]) begin
            mem_rvalid_o = 1'b1;
            mem_err_o    = rsp_head[i].err;
            mem_rdata_o  = rsp_head[i].rdata;
            rsp_pop[i]   = 1'b1;
          end
        end
      end
    end
  end

  // Outstanding request count; simultaneous accept and return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_reg <= '0;
    end else begin
      case ({accept, mem_rvalid_o})
        2'b10:   out_cnt_reg <= out_cnt_reg + 1'b1;
        2'b01:   out_cnt_reg <= out_cnt_reg - 1'b1;
        default: out_cnt_reg <= out_cnt_reg;
      endcase
    end
  end

  // Sticky flag for responses from a target that owed nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_reg <= 1'b0;
    end else if (|stray) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_reg;

endmodule

// File: tb/tb_vproc_mem_router.sv
// Directed bench for vproc_mem_router with the default two-target map:
// target 0 = 0x0000_0000/256K (+0x2000), target 1 = 0x0004_0000/256K (+0).
module tb_vproc_mem_router;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_gnt_o;
  logic [31:0] mem_addr_i = '0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_be_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_rvalid_o;
  logic        mem_err_o;
  logic [31:0] mem_rdata_o;
  logic [1:0]  tgt_req_o;
  logic [31:0] tgt_addr_o;
  logic        tgt_we_o;
  logic [3:0]  tgt_be_o;
  logic [31:0] tgt_wdata_o;
  logic [1:0]  tgt_rvalid_i = '0;
  logic [1:0]  tgt_err_i = '0;
  logic [63:0] tgt_rdata_i = '0;
  logic        proto_err_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vproc_mem_router dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_i    (mem_req_i),
    .mem_gnt_o    (mem_gnt_o),
    .mem_addr_i   (mem_addr_i),
    .mem_we_i     (mem_we_i),
    .mem_be_i     (mem_be_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_rvalid_o (mem_rvalid_o),
    .mem_err_o    (mem_err_o),
    .mem_rdata_o  (mem_rdata_o),
    .tgt_req_o    (tgt_req_o),
    .tgt_addr_o   (tgt_addr_o),
    .tgt_we_o     (tgt_we_o),
    .tgt_be_o     (tgt_be_o),
    .tgt_wdata_o  (tgt_wdata_o),
    .tgt_rvalid_i (tgt_rvalid_i),
    .tgt_err_i    (tgt_err_i),
    .tgt_rdata_i  (tgt_rdata_i),
    .proto_err_o  (proto_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_req_i    = 1'b0;
    mem_we_i     = 1'b0;
    mem_wdata_i  = '0;
    tgt_rvalid_i = '0;
    tgt_err_i    = '0;
    tgt_rdata_i  = '0;
  endtask

  initial begin : stim
    int bp_rsp_cyc [5];
    int bp_out_cyc [5];
    logic exp_gnt;
    logic exp_rv;
    logic [31:0] exp_data;
    bp_rsp_cyc = '{10, 11, 12, 13, 22};
    bp_out_cyc = '{11, 12, 13, 14, 23};

    // ---- reset held for 3 cycles with a request pending ----
    mem_req_i  = 1'b1;
    mem_addr_i = 32'h0000_0100;
    mem_be_i   = 4'hF;
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_gnt_%0d", k), mem_gnt_o, 0);
      check($sformatf("rst_treq_%0d", k), tgt_req_o, 0);
      check($sformatf("rst_taddr_%0d", k), tgt_addr_o, 0);
      check($sformatf("rst_rvalid_%0d", k), mem_rvalid_o, 0);
      check($sformatf("rst_rdata_%0d", k), mem_rdata_o, 0);
      check($sformatf("rst_proto_%0d", k), proto_err_o, 0);
    end
    tick();
    rst = 1'b0;
    mem_req_i = 1'b0;
    #1;
    check("post_rst_gnt", mem_gnt_o, 1);

    // ---- read target 0 at 0x100, latency 1 ----
    tick();
    mem_req_i = 1'b1; mem_addr_i = 32'h0000_0100;
    #1;
    check("rd0_gnt", mem_gnt_o, 1);
    check("rd0_treq", tgt_req_o, 2'b01);
    check("rd0_taddr", tgt_addr_o, 32'h0000_2100);
    tick();
    quiet();
    tgt_rvalid_i = 2'b01; tgt_rdata_i[31:0] = 32'hDEAD_BEEF;
    #1;
    check("rd0_early", mem_rvalid_o, 0);
    tick();
    quiet();
    #1;
    check("rd0_rvalid", mem_rvalid_o, 1);
    check("rd0_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    check("rd0_err", mem_err_o, 0);
    tick();
    check("rd0_done", mem_rvalid_o, 0);

    // ---- ordering: A to tgt0 (lat 5) then B to tgt1 (lat 1) ----
    mem_req_i = 1'b1; mem_addr_i = 32'h0000_0200;
    #1;
    check("ord_a_treq", tgt_req_o, 2'b01);
    tick();
    mem_addr_i = 32'h0004_0010;
    #1;
    check("ord_b_treq", tgt_req_o, 2'b10);
    check("ord_b_taddr", tgt_addr_o, 32'h0004_0010);
    tick();                                             // cycle 2
    quiet();
    tgt_rvalid_i = 2'b10; tgt_rdata_i[63:32] = 32'h2222_2222;
    #1;
    check("ord_c2", mem_rvalid_o, 0);
    tick(); quiet(); #1;                                // cycle 3
    check("ord_c3", mem_rvalid_o, 0);
    tick(); #1;                                         // cycle 4
    check("ord_c4", mem_rvalid_o, 0);
    tick();                                             // cycle 5
    tgt_rvalid_i = 2'b01; tgt_rdata_i[31:0] = 32'h1111_1111;
    #1;
    check("ord_c5", mem_rvalid_o, 0);
    tick(); quiet(); #1;                                // cycle 6
    check("ord_a_rvalid", mem_rvalid_o, 1);
    check("ord_a_rdata", mem_rdata_o, 32'h1111_1111);
    tick(); #1;                                         // cycle 7
    check("ord_b_rvalid", mem_rvalid_o, 1);
    check("ord_b_rdata", mem_rdata_o, 32'h2222_2222);
    tick(); #1;
    check("ord_done", mem_rvalid_o, 0);

    // ---- decode error ----
    tick();
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0000;
    #1;
    check("dec_gnt", mem_gnt_o, 1);
    check("dec_treq", tgt_req_o, 2'b00);
    tick(); quiet(); #1;
    check("dec_rvalid", mem_rvalid_o, 1);
    check("dec_err", mem_err_o, 1);
    check("dec_rdata", mem_rdata_o, 0);
    tick();
    check("dec_done", mem_rvalid_o, 0);

    // ---- write to target 1 with a target error ----
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'b0110;
    mem_wdata_i = 32'hCAFE_F00D; mem_addr_i = 32'h0004_0020;
    #1;
    check("wr_treq", tgt_req_o, 2'b10);
    check("wr_taddr", tgt_addr_o, 32'h0004_0020);
    check("wr_we", tgt_we_o, 1);
    check("wr_be", tgt_be_o, 4'b0110);
    check("wr_wdata", tgt_wdata_o, 32'hCAFE_F00D);
    tick();
    quiet();
    mem_be_i = 4'hF;
    tgt_rvalid_i = 2'b10; tgt_err_i = 2'b10; tgt_rdata_i[63:32] = 32'h0000_5555;
    #1;
    check("wr_early", mem_rvalid_o, 0);
    tick(); quiet(); #1;
    check("wr_rvalid", mem_rvalid_o, 1);
    check("wr_err", mem_err_o, 1);
    check("wr_rdata", mem_rdata_o, 32'h0000_5555);

    // ---- window edges: last word of tgt0, first address past tgt1 ----
    tick();
    mem_req_i = 1'b1; mem_addr_i = 32'h0003_FFFC;
    #1;
    check("edge_t0_treq", tgt_req_o, 2'b01);
    check("edge_t0_taddr", tgt_addr_o, 32'h0004_1FFC);
    tick();
    mem_addr_i = 32'h0008_0000;
    tgt_rvalid_i = 2'b01; tgt_rdata_i[31:0] = 32'h0000_0077;
    #1;
    check("edge_miss_treq", tgt_req_o, 2'b00);
    tick(); quiet(); #1;
    check("edge_t0_rvalid", mem_rvalid_o, 1);
    check("edge_t0_err", mem_err_o, 0);
    check("edge_t0_rdata", mem_rdata_o, 32'h0000_0077);
    tick(); #1;
    check("edge_miss_rvalid", mem_rvalid_o, 1);
    check("edge_miss_err", mem_err_o, 1);
    tick(); #1;
    check("edge_done", mem_rvalid_o, 0);

    // ---- back-pressure: 5 reads to tgt0, latency 10 ----
    mem_addr_i = 32'h0000_0300;
    for (int cyc = 0; cyc < 25; cyc++) begin
      tick();
      quiet();
      mem_req_i = (cyc <= 12);
      for (int j = 0; j < 5; j++) begin
        if (cyc == bp_rsp_cyc[j]) begin
          tgt_rvalid_i = 2'b01;
          tgt_rdata_i[31:0] = 32'hA000_0000 + 32'(j);
        end
      end
      #1;
      if (cyc <= 12) begin
        exp_gnt = (cyc < 4) || (cyc >= 12);
        check($sformatf("bp_gnt_c%0d", cyc), mem_gnt_o, 64'(exp_gnt));
        check($sformatf("bp_treq_c%0d", cyc), tgt_req_o, exp_gnt ? 2'b01 : 2'b00);
        if (exp_gnt) check($sformatf("bp_taddr_c%0d", cyc), tgt_addr_o, 32'h0000_2300);
      end
      exp_rv = 1'b0;
      exp_data = '0;
      for (int j = 0; j < 5; j++) begin
        if (cyc == bp_out_cyc[j]) begin
          exp_rv = 1'b1;
          exp_data = 32'hA000_0000 + 32'(j);
        end
      end
      check($sformatf("bp_rvalid_c%0d", cyc), mem_rvalid_o, 64'(exp_rv));
      if (exp_rv) check($sformatf("bp_rdata_c%0d", cyc), mem_rdata_o, 64'(exp_data));
    end

    // ---- stray response on target 1 ----
    tick();
    quiet();
    tgt_rvalid_i = 2'b10; tgt_rdata_i[63:32] = 32'h0BAD_0BAD;
    #1;
    check("stray_proto_pre", proto_err_o, 0);
    check("stray_rvalid", mem_rvalid_o, 0);
    tick(); quiet(); #1;
    check("stray_proto_set", proto_err_o, 1);
    check("stray_rvalid_next", mem_rvalid_o, 0);
    tick(); tick(); #1;
    check("stray_proto_hold", proto_err_o, 1);
    rst = 1'b1;
    #1;
    check("stray_proto_rst", proto_err_o, 0);
    check("stray_gnt_rst", mem_gnt_o, 0);
    tick();
    rst = 1'b0;
    #1;
    check("final_gnt", mem_gnt_o, 1);
    check("final_proto", proto_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
